// File: rtl/contador_garrafas.sv
// Bottle counter front end: sensor synchroniser, debounce FSM,
// modulo-dozen bottle counter with a one-cycle dozen pulse.
module contador_garrafas #(
  parameter int unsigned DEBOUNCE_CYCLES    = 4,
  parameter int unsigned GARRAFAS_POR_DUZIA = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       sensor,
  input  logic       clear,
  output logic [3:0] garrafas,
  output logic       presente,
  output logic       duzia_pulse
);

  typedef enum logic [1:0] {
    AUSENTE,
    CONFIRMA_SUBIDA,
    PRESENTE,
    CONFIRMA_DESCIDA
  } estado_t;

  localparam logic [3:0] DEB_LAST  = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] GARR_LAST = 4'(GARRAFAS_POR_DUZIA - 1);
  localparam bit         DEB_UM    = (DEBOUNCE_CYCLES == 1);

  logic [1:0] sync_q;
  logic       s_sync;
  estado_t    estado_q, estado_d;
  logic [3:0] deb_q, deb_d;
  logic [3:0] garr_q, garr_d;
  logic       pulse_q, pulse_d;
  logic       conta;

  assign s_sync = sync_q[1];

  // Two-flop synchroniser for the asynchronous sensor
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], sensor};
  end

  // Debounce FSM and bottle counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q <= AUSENTE;
      deb_q    <= 4'd0;
      garr_q   <= 4'd0;
      pulse_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      deb_q    <= deb_d;
      garr_q   <= garr_d;
      pulse_q  <= pulse_d;
    end
  end

  // Next state of the filter; conta marks accepted rising edges
  always_comb begin
    estado_d = estado_q;
    deb_d    = deb_q;
    conta    = 1'b0;
    unique case (estado_q)
      AUSENTE: begin
        if (s_sync) begin
          if (DEB_UM) begin
            estado_d = PRESENTE;
            deb_d    = 4'd0;
            conta    = 1'b1;
          end else begin
            estado_d = CONFIRMA_SUBIDA;
            deb_d    = 4'd1;
          end
        end
      end
      CONFIRMA_SUBIDA: begin
        if (!s_sync) begin
          estado_d = AUSENTE;
          deb_d    = 4'd0;
        end else if (deb_q == DEB_LAST) begin
          estado_d = PRESENTE;
          deb_d    = 4'd0;
          conta    = 1'b1;
        end else begin
          deb_d = deb_q + 4'd1;
        end
      end
      PRESENTE: begin
        if (!s_sync) begin
          if (DEB_UM) begin
            estado_d = AUSENTE;
            deb_d    = 4'd0;
          end else begin
            estado_d = CONFIRMA_DESCIDA;
            deb_d    = 4'd1;
          end
        end
      end
      CONFIRMA_DESCIDA: begin
        if (s_sync) begin
          estado_d = PRESENTE;
          deb_d    = 4'd0;
        end else if (deb_q == DEB_LAST) begin
          estado_d = AUSENTE;
          deb_d    = 4'd0;
        end else begin
          deb_d = deb_q + 4'd1;
        end
      end
      default: begin
        estado_d = AUSENTE;
        deb_d    = 4'd0;
      end
    endcase
  end

  // Partial count: clear beats count, disabled bottles are dropped
  always_comb begin
    garr_d  = garr_q;
    pulse_d = 1'b0;
    if (clear) begin
      garr_d = 4'd0;
    end else if (conta && enable) begin
      if (garr_q == GARR_LAST) begin
        garr_d  = 4'd0;
        pulse_d = 1'b1;
      end else begin
        garr_d = garr_q + 4'd1;
      end
    end
  end

  assign garrafas    = garr_q;
  assign duzia_pulse = pulse_q;
  assign presente    = (estado_q == PRESENTE) ||
                       (estado_q == CONFIRMA_DESCIDA);

endmodule

// File: tb/tb_contador_garrafas.sv
// Bench for contador_garrafas: directed bottles, scoreboard
// of output changes plus timed latency checks.
module tb_contador_garrafas;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       sensor = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] garrafas;
  logic       presente;
  logic       duzia_pulse;

  int checks = 0;
  int failures = 0;
  int model_g = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  contador_garrafas #(
    .DEBOUNCE_CYCLES(4),
    .GARRAFAS_POR_DUZIA(12)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .sensor(sensor),
    .clear(clear),
    .garrafas(garrafas),
    .presente(presente),
    .duzia_pulse(duzia_pulse)
  );

  task automatic chk(input string nm, input int act,
                     input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input int g, input bit p);
    exp_q.push_back({4'(g), p});
  endtask

  task automatic bottle(input int hi, input int lo);
    sensor = 1'b1;
    repeat (hi) tick();
    sensor = 1'b0;
    repeat (lo) tick();
  endtask

  // Clean bottle counted with enable high
  task automatic count_bottle();
    if (model_g == 11) begin
      model_g = 0;
      push(0, 1'b1);
      push(0, 1'b0);
    end else begin
      model_g++;
      push(model_g, 1'b0);
    end
    bottle(10, 10);
  endtask

  // Monitor: every output change must match the next expectation
  initial begin
    logic [4:0] prev;
    logic [4:0] cur;
    logic [4:0] e;
    prev = 5'b0;
    @(posedge reset);
    forever begin
      @(negedge clk);
      cur = {garrafas, duzia_pulse};
      if (cur[0])
        chk("pulse_width", int'(prev[0]), 0);
      if (cur != prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got g=%0d p=%0d",
                   cur[4:1], cur[0]);
        end else begin
          e = exp_q.pop_front();
          chk("sb_garrafas", int'(cur[4:1]), int'(e[4:1]));
          chk("sb_pulse", int'(cur[0]), int'(e[0]));
        end
      end
      prev = cur;
    end
  end

  initial begin
    static int up[5] = '{1, 0, 1, 1, 0};
    static int dn[5] = '{0, 1, 0, 0, 1};
    bit seen;

    #1 reset = 1'b0;
    #3;
    chk("rst_garrafas", int'(garrafas), 0);
    chk("rst_presente", int'(presente), 0);
    chk("rst_pulse", int'(duzia_pulse), 0);
    tick();
    tick();
    reset = 1'b1;
    enable = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 11; i++) count_bottle();
    chk("pre_dozen", int'(garrafas), 11);
    push(0, 1'b1);
    push(0, 1'b0);
    sensor = 1'b1;
    repeat (6) tick();
    chk("dozen_pulse_e6", int'(duzia_pulse), 1);
    chk("dozen_garr_e6", int'(garrafas), 0);
    tick();
    chk("dozen_pulse_e7", int'(duzia_pulse), 0);
    repeat (3) tick();
    sensor = 1'b0;
    repeat (10) tick();
    model_g = 0;

    seen = 1'b0;
    sensor = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) sensor = 1'b0;
      tick();
      if (presente) seen = 1'b1;
    end
    chk("glitch3_presente", int'(seen), 0);
    chk("glitch3_garrafas", int'(garrafas), 0);

    push(1, 1'b0);
    sensor = 1'b1;
    repeat (4) tick();
    sensor = 1'b0;
    tick();
    chk("pulse4_e5", int'(garrafas), 0);
    tick();
    chk("pulse4_e6", int'(garrafas), 1);
    chk("pulse4_presente", int'(presente), 1);
    repeat (10) tick();
    chk("pulse4_fall", int'(presente), 0);
    model_g = 1;

    push(2, 1'b0);
    foreach (up[i]) begin
      sensor = up[i][0];
      tick();
    end
    sensor = 1'b1;
    repeat (10) tick();
    foreach (dn[i]) begin
      sensor = dn[i][0];
      tick();
    end
    sensor = 1'b0;
    repeat (10) tick();
    chk("bounce_garrafas", int'(garrafas), 2);
    model_g = 2;

    for (int i = 0; i < 9; i++) count_bottle();
    push(0, 1'b0);
    sensor = 1'b1;
    repeat (5) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_edge_garr", int'(garrafas), 0);
    chk("clr_edge_pulse", int'(duzia_pulse), 0);
    tick();
    chk("clr_edge_pulse2", int'(duzia_pulse), 0);
    repeat (3) tick();
    sensor = 1'b0;
    repeat (10) tick();
    model_g = 0;
    count_bottle();
    chk("after_clr", int'(garrafas), 1);

    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sensor = 1'b1;
      repeat (7) tick();
      chk("en0_presente", int'(presente), 1);
      repeat (3) tick();
      sensor = 1'b0;
      repeat (10) tick();
      chk("en0_fall", int'(presente), 0);
    end
    chk("en0_garrafas", int'(garrafas), 1);
    sensor = 1'b1;
    repeat (7) tick();
    enable = 1'b1;
    repeat (3) tick();
    sensor = 1'b0;
    repeat (10) tick();
    chk("en_late_garr", int'(garrafas), 1);

    for (int i = 0; i < 6; i++) count_bottle();
    chk("pre_rst_garr", int'(garrafas), 7);
    sensor = 1'b1;
    repeat (3) tick();
    push(0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("arst_garrafas", int'(garrafas), 0);
    chk("arst_presente", int'(presente), 0);
    chk("arst_pulse", int'(duzia_pulse), 0);
    tick();
    reset = 1'b1;
    push(1, 1'b0);
    repeat (5) tick();
    chk("rel_e5", int'(garrafas), 0);
    tick();
    chk("rel_e6", int'(garrafas), 1);

    push(0, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_idle_garr", int'(garrafas), 0);
    chk("clr_idle_pres", int'(presente), 1);
    repeat (3) tick();
    sensor = 1'b0;
    repeat (10) tick();
    chk("final_presente", int'(presente), 0);

    repeat (3) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
